// File: rtl/if_fetch_if.sv
// Instruction-memory fetch bus: a single request/ready handshake, with data
// returned in the same cycle as ready.
interface if_fetch_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, a one-entry skid buffer for ID stalls,
// delayed-branch redirects and exception redirects, feeding the IF/ID register.
module if_fetch (
    input  logic              clock,
    input  logic              reset_n,
    if_fetch_if.master        imem,
    input  logic              ID_Stall,
    input  logic [1:0]        ID_PCSrc,
    input  logic [31:0]       ID_ReadData1,
    input  logic [31:0]       ID_BranchAddress,
    input  logic [31:0]       ID_JumpAddress,
    input  logic              ID_PCSrc_Exc,
    input  logic [31:0]       ID_ExceptionPC,
    input  logic              IF_Flush,
    output logic [31:0]       Instruction,
    output logic [31:0]       ID_PCAdd4,
    output logic [31:0]       ID_RestartPC,
    output logic              ID_IsBDS,
    output logic              ID_IsFlushed
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_FULL = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        bds_next;
    logic        flush_next;
    logic [29:0] drop_addr;

    logic        accept;
    logic        avail;
    logic [31:0] avail_instr;
    logic [31:0] avail_pc;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        redirect;
    logic        slot_done;
    logic        mark_bds;

    // DROP keeps presenting the abandoned address until the memory completes it.
    assign imem.imem_req  = (state != S_FULL);
    assign imem.imem_addr = (state == S_DROP) ? drop_addr : pc[31:2];

    assign accept      = (state == S_REQ) && imem.imem_ready;
    assign avail       = accept || ((state == S_FULL) && buf_valid);
    assign avail_instr = (state == S_FULL) ? buf_instr : imem.imem_rdata;
    assign avail_pc    = (state == S_FULL) ? buf_pc : pc;
    assign seq_pc      = pend_valid ? pend_target : pc + 32'd4;

    always_comb begin
        target = ID_JumpAddress;
        case (ID_PCSrc)
            2'b01:   target = ID_ReadData1;
            2'b10:   target = ID_BranchAddress;
            default: target = ID_JumpAddress;
        endcase
    end

    assign redirect = (ID_PCSrc != 2'b00) && !ID_Stall && !ID_IsFlushed && !ID_PCSrc_Exc;
    // The delay slot counts as accepted once pc has moved past it, or if it is
    // being accepted in this very cycle (accept wins over a same-cycle redirect).
    assign slot_done = (pc != ID_PCAdd4) || accept;
    assign mark_bds  = bds_next || redirect;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            buf_valid    <= 1'b0;
            buf_instr    <= 32'd0;
            buf_pc       <= 32'd0;
            pend_valid   <= 1'b0;
            pend_target  <= 32'd0;
            bds_next     <= 1'b0;
            flush_next   <= 1'b0;
            drop_addr    <= 30'd0;
            Instruction  <= 32'd0;
            ID_PCAdd4    <= 32'd0;
            ID_RestartPC <= 32'd0;
            ID_IsBDS     <= 1'b0;
            ID_IsFlushed <= 1'b1;
        end else if (ID_PCSrc_Exc) begin
            pc           <= ID_ExceptionPC;
            buf_valid    <= 1'b0;
            pend_valid   <= 1'b0;
            bds_next     <= 1'b0;
            flush_next   <= 1'b0;
            Instruction  <= 32'd0;
            ID_IsBDS     <= 1'b0;
            ID_IsFlushed <= 1'b1;
            if ((state == S_REQ || state == S_DROP) && !imem.imem_ready) begin
                state <= S_DROP;
                if (state == S_REQ) drop_addr <= pc[31:2];
            end else begin
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        pc         <= seq_pc;
                        pend_valid <= 1'b0;
                        if (ID_Stall) begin
                            buf_valid <= 1'b1;
                            buf_instr <= imem.imem_rdata;
                            buf_pc    <= pc;
                            state     <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!ID_Stall) begin
                        buf_valid <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.imem_ready) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase

            if (redirect) begin
                if (slot_done) begin
                    pc         <= target;
                    pend_valid <= 1'b0;
                    if (state == S_REQ && !accept) begin
                        state     <= S_DROP;
                        drop_addr <= pc[31:2];
                    end
                end else begin
                    pend_valid  <= 1'b1;
                    pend_target <= target;
                end
            end

            if (!ID_Stall) begin
                if (avail) begin
                    if (flush_next || IF_Flush) begin
                        Instruction  <= 32'd0;
                        ID_IsBDS     <= 1'b0;
                        ID_IsFlushed <= 1'b1;
                    end else begin
                        Instruction  <= avail_instr;
                        ID_PCAdd4    <= avail_pc + 32'd4;
                        ID_RestartPC <= mark_bds ? avail_pc - 32'd4 : avail_pc;
                        ID_IsBDS     <= mark_bds;
                        ID_IsFlushed <= 1'b0;
                    end
                    // A nullified delay slot consumes the BDS mark as well.
                    bds_next   <= 1'b0;
                    flush_next <= 1'b0;
                end else begin
                    Instruction  <= 32'd0;
                    ID_IsBDS     <= 1'b0;
                    ID_IsFlushed <= 1'b1;
                    if (redirect) bds_next   <= 1'b1;
                    if (IF_Flush) flush_next <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, stall buffering, delayed branch,
// flushed delay slot, exception drop, pc wrap and reset mid-request.
module tb_if_fetch;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        ID_Stall, ID_PCSrc_Exc, IF_Flush;
    logic [1:0]  ID_PCSrc;
    logic [31:0] ID_ReadData1, ID_BranchAddress, ID_JumpAddress, ID_ExceptionPC;
    logic [31:0] Instruction, ID_PCAdd4, ID_RestartPC;
    logic        ID_IsBDS, ID_IsFlushed;
    logic        use_const;
    int          checks = 0;
    int          errors = 0;

    if_fetch_if bus ();

    // Memory returns a constant word, or the fetched byte address with bit 0 set.
    assign bus.imem_rdata = use_const ? 32'h2408_0001 : {bus.imem_addr, 2'b01};

    if_fetch dut (
        .clock(clock), .reset_n(reset_n), .imem(bus),
        .ID_Stall(ID_Stall), .ID_PCSrc(ID_PCSrc), .ID_ReadData1(ID_ReadData1),
        .ID_BranchAddress(ID_BranchAddress), .ID_JumpAddress(ID_JumpAddress),
        .ID_PCSrc_Exc(ID_PCSrc_Exc), .ID_ExceptionPC(ID_ExceptionPC), .IF_Flush(IF_Flush),
        .Instruction(Instruction), .ID_PCAdd4(ID_PCAdd4), .ID_RestartPC(ID_RestartPC),
        .ID_IsBDS(ID_IsBDS), .ID_IsFlushed(ID_IsFlushed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; ID_Stall = 1'b0; ID_PCSrc = 2'b00; ID_PCSrc_Exc = 1'b0; IF_Flush = 1'b0;
        ID_ReadData1 = 32'd0; ID_BranchAddress = 32'd0; ID_JumpAddress = 32'd0;
        ID_ExceptionPC = 32'd0; use_const = 1'b1; bus.imem_ready = 1'b0;
        step(); step();
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_pcadd4", ID_PCAdd4, 32'h0);
        chk("rst_restart", ID_RestartPC, 32'h0);
        chk("rst_bds", {31'd0, ID_IsBDS}, 32'h0);
        chk("rst_flushed", {31'd0, ID_IsFlushed}, 32'h1);
        chk("rst_addr", {2'b0, bus.imem_addr}, 32'h2FF0_0000);

        // Streaming after reset release
        reset_n = 1'b1; bus.imem_ready = 1'b1;
        chk("rel_req", {31'd0, bus.imem_req}, 32'h1);
        step();
        chk("s_instr", Instruction, 32'h2408_0001);
        chk("s_pcadd4", ID_PCAdd4, 32'hBFC0_0004);
        chk("s_restart", ID_RestartPC, 32'hBFC0_0000);
        chk("s_flushed", {31'd0, ID_IsFlushed}, 32'h0);
        chk("s_addr1", {2'b0, bus.imem_addr}, 32'h2FF0_0001);

        // Three stall cycles with ready held high
        use_const = 1'b0; ID_Stall = 1'b1;
        step();
        chk("st_req0a", {31'd0, bus.imem_req}, 32'h0);
        chk("st_hold", Instruction, 32'h2408_0001);
        step();
        chk("st_req0b", {31'd0, bus.imem_req}, 32'h0);
        chk("st_hold2", ID_PCAdd4, 32'hBFC0_0004);
        step();
        ID_Stall = 1'b0;
        step();
        chk("st_buf", Instruction, 32'hBFC0_0005);
        chk("st_bufpc", ID_PCAdd4, 32'hBFC0_0008);
        chk("st_resume", {2'b0, bus.imem_addr}, 32'h2FF0_0002);
        step();
        chk("st_next", Instruction, 32'hBFC0_0009);

        // Move pc to 0x100 with an exception, then branch with the slot not yet fetched
        ID_PCSrc_Exc = 1'b1; ID_ExceptionPC = 32'h0000_0100;
        step();
        ID_PCSrc_Exc = 1'b0;
        chk("e1_bubble", {31'd0, ID_IsFlushed}, 32'h1);
        step();
        chk("br_instr", Instruction, 32'h0000_0101);
        ID_PCSrc = 2'b10; ID_BranchAddress = 32'h0000_0200; bus.imem_ready = 1'b0;
        step();
        ID_PCSrc = 2'b00;
        chk("br_pend_addr", {2'b0, bus.imem_addr}, 32'h0000_0041);
        chk("br_bubble", Instruction, 32'h0);
        bus.imem_ready = 1'b1;
        step();
        chk("bds_instr", Instruction, 32'h0000_0105);
        chk("bds_flag", {31'd0, ID_IsBDS}, 32'h1);
        chk("bds_restart", ID_RestartPC, 32'h0000_0100);
        chk("bds_tgt_addr", {2'b0, bus.imem_addr}, 32'h0000_0080);
        step();
        chk("tgt_instr", Instruction, 32'h0000_0201);
        chk("tgt_bds", {31'd0, ID_IsBDS}, 32'h0);
        chk("tgt_restart", ID_RestartPC, 32'h0000_0200);

        // Jump with delay slot nullified, slot accepted in the redirect cycle
        ID_PCSrc = 2'b11; ID_JumpAddress = 32'h0000_0300; IF_Flush = 1'b1;
        step();
        ID_PCSrc = 2'b00; IF_Flush = 1'b0;
        chk("fl_instr", Instruction, 32'h0);
        chk("fl_flushed", {31'd0, ID_IsFlushed}, 32'h1);
        chk("fl_bds", {31'd0, ID_IsBDS}, 32'h0);
        chk("fl_addr", {2'b0, bus.imem_addr}, 32'h0000_00C0);
        step();
        chk("fl_tgt", Instruction, 32'h0000_0301);
        chk("fl_tgt_fl", {31'd0, ID_IsFlushed}, 32'h0);

        // Exception while the request at 0x304 is stalled
        bus.imem_ready = 1'b0;
        step();
        ID_PCSrc_Exc = 1'b1; ID_ExceptionPC = 32'h8000_0180;
        step();
        ID_PCSrc_Exc = 1'b0;
        chk("dr_addr", {2'b0, bus.imem_addr}, 32'h0000_00C1);
        chk("dr_req", {31'd0, bus.imem_req}, 32'h1);
        chk("dr_bubble", {31'd0, ID_IsFlushed}, 32'h1);
        step();
        chk("dr_hold", {2'b0, bus.imem_addr}, 32'h0000_00C1);
        bus.imem_ready = 1'b1;
        step();
        chk("dr_discard", Instruction, 32'h0);
        chk("dr_newaddr", {2'b0, bus.imem_addr}, 32'h2000_0060);
        step();
        chk("dr_exc_instr", Instruction, 32'h8000_0181);
        chk("dr_exc_pc4", ID_PCAdd4, 32'h8000_0184);

        // Sequential wrap at the top of the address space
        ID_PCSrc_Exc = 1'b1; ID_ExceptionPC = 32'hFFFF_FFFC;
        step();
        ID_PCSrc_Exc = 1'b0;
        chk("wr_addr", {2'b0, bus.imem_addr}, 32'h3FFF_FFFF);
        step();
        chk("wr_instr", Instruction, 32'hFFFF_FFFD);
        chk("wr_pcadd4", ID_PCAdd4, 32'h0);
        chk("wr_next", {2'b0, bus.imem_addr}, 32'h0);

        // Reset during an outstanding request: no DROP after release
        bus.imem_ready = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("mr_instr", Instruction, 32'h0);
        chk("mr_addr", {2'b0, bus.imem_addr}, 32'h2FF0_0000);
        step();
        reset_n = 1'b1;
        step();
        chk("mr_rel_addr", {2'b0, bus.imem_addr}, 32'h2FF0_0000);
        bus.imem_ready = 1'b1;
        step();
        chk("mr_first", Instruction, 32'hBFC0_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have ports: clock in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-002 SHALL have imem_req out 1 (fetch request), imem_addr out 30 (word address, PC[31:2]), imem_ready in 1 (accept plus data valid, same cycle), imem_rdata in 32 (instruction word).
REQ-003 SHALL have ID_Stall in 1 (ID holds its instruction); ID_PCSrc in 2 (00 seq, 01 JR, 10 branch, 11 jump); ID_ReadData1, ID_BranchAddress, ID_JumpAddress in 32 each (targets for 01/10/11).
REQ-004 SHALL have ID_PCSrc_Exc in 1 (exception redirect); ID_ExceptionPC in 32; IF_Flush in 1 (nullify delay slot).
REQ-005 SHALL have outputs Instruction 32, ID_PCAdd4 32, ID_RestartPC 32, ID_IsBDS 1, ID_IsFlushed 1 (IF/ID register, ifid_out view).

Function
REQ-006 SHALL keep the fetch PC register (pc) and issue imem_req=1, imem_addr=pc[31:2] in state REQ.
REQ-007 SHALL hold imem_addr stable while imem_req=1 and imem_ready=0.
REQ-008 SHALL implement FSM states REQ, FULL and DROP.
REQ-009 REQ, imem_ready=1, ID_Stall=0: SHALL load the word directly into the ID register; pc advances; stays REQ.
REQ-010 REQ, imem_ready=1, ID_Stall=1: SHALL store word and pc in a 1-entry buffer and go to FULL; imem_req=0 in FULL.
REQ-011 FULL, ID_Stall=0: SHALL load the buffer into ID, clear the buffer and go to REQ; fetch resumes the next cycle.
REQ-012 SHALL load a bubble (Instruction=0, ID_IsFlushed=1, ID_IsBDS=0) into ID when ID_Stall=0 and no instruction is available.
REQ-013 SHALL hold all ID outputs unchanged when ID_Stall=1, except on exception (REQ-018).
REQ-014 A loaded instruction at address P SHALL set ID_PCAdd4=P+4, ID_RestartPC=P (or P-4 if ID_IsBDS=1), ID_IsFlushed=0.
REQ-015 Sequential next pc SHALL be P+4 with 32-bit wrap, no carry-out.
REQ-016 A redirect SHALL be taken when ID_PCSrc!=00, ID_Stall=0 and ID_IsFlushed=0, with target selected per REQ-003. If the delay slot (address ID_PCAdd4) is not yet accepted, the target SHALL be latched as pending and applied as next pc when the delay slot is accepted. Otherwise pc SHALL become the target immediately, and an outstanding request enters DROP.
REQ-017 The first non-bubble instruction loaded into ID after a redirect SHALL carry ID_IsBDS=1.
REQ-018 ID_PCSrc_Exc=1 SHALL have highest priority and SHALL, in that cycle: set pc=ID_ExceptionPC; clear buffer, pending target and BDS/flush flags; load a bubble into ID regardless of ID_Stall. An outstanding unaccepted request goes to DROP; otherwise the FSM goes to REQ.
REQ-019 DROP SHALL keep imem_req=1 with the old address until imem_ready=1, discard that data, then go to REQ at the new pc.
REQ-020 IF_Flush=1 with ID_Stall=0 SHALL replace the next instruction destined for ID (the delay slot) with a bubble; fetch sequencing is unaffected.
REQ-021 Simultaneous redirect (REQ-016) and imem_ready in the same cycle SHALL be resolved as if the accept occurred first.

Reset
REQ-022 While reset_n=0: pc=0xBFC00000, state=REQ, buffer and pending empty, Instruction=0, ID_PCAdd4=0, ID_RestartPC=0, ID_IsBDS=0, ID_IsFlushed=1; imem_req=1 from the first cycle after release.
REQ-023 Reset asserted mid-request SHALL abandon the request with no DROP state after release.

Verification
REQ-024 Release reset, imem_ready=1 each cycle, rdata=0x24080001 -> imem_addr 0x2FF00000, 0x2FF00001, ...; next cycle Instruction=0x24080001, ID_PCAdd4=0xBFC00004.
REQ-025 ID_Stall=1 for 3 cycles while ready=1 -> one word buffered, imem_req=0 for 2 cycles, ID held; on release ID gets buffered word, no word lost or duplicated.
REQ-026 Branch at 0x100 in ID, ID_PCSrc=10, ID_BranchAddress=0x200, delay slot not yet accepted -> next fetches 0x104 then 0x200; 0x104 has ID_IsBDS=1, ID_RestartPC=0x100.
REQ-027 ID_PCSrc_Exc=1, ID_ExceptionPC=0x80000180 while request stalled (ready=0) -> DROP, old address held, data discarded on ready, next fetch 0x80000180, ID bubble.
REQ-028 IF_Flush=1 with branch -> delay slot appears in ID as Instruction=0, ID_IsFlushed=1; target fetched next.
REQ-029 pc=0xFFFFFFFC sequential -> next pc 0x00000000.
